// File: rtl/uart_tx_axis_pkg.sv
// Shared UART definitions for the transmitter and the receiver that decodes its line.
// Holds the FSM state encodings, parity-mode codes and the baud divider derivation.
package uart_tx_axis_pkg;

  localparam int unsigned STATE_W = 3;

  // Frame FSM state encodings
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  // Parity modes decoded from the PARITY string parameter
  localparam logic [1:0] PAR_NONE    = 2'd0;
  localparam logic [1:0] PAR_EVEN    = 2'd1;
  localparam logic [1:0] PAR_ODD     = 2'd2;
  localparam logic [1:0] PAR_INVALID = 2'd3;

  // Clocks per bit, truncating integer division
  function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_axis_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last clock of each bit.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   restart      holds the counter at zero (used while the line is idle)
//   bit_done_c   combinational pulse during the final clock of a bit period
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_done_c
);

  localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] baud_cnt;

  assign bit_done_c = (baud_cnt == CNT_LAST);

  // Wraps to zero on the last count so it never leaves 0..BAUD_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (restart || bit_done_c) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-Stream style valid/ready handshake.
// Sends start bit, DATA_BITS payload LSB-first, optional parity bit and stop bit(s).
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   s_axis_tdata    word to send, latched at the handshake edge
//   s_axis_tvalid   source has a word
//   s_axis_tready   high while the FSM is idle (registered, low in reset)
//   tx              serial line, idle high (registered)
//   busy            high from the clock after the handshake to the end of the last stop bit
module uart_tx_axis
  import uart_tx_axis_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter string       PARITY    = "even",
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BAUD_DIV  = calc_baud_div(CLK_FREQ, BAUD);
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [1:0]  PAR_MODE  = (PARITY == "none") ? PAR_NONE :
                                      (PARITY == "even") ? PAR_EVEN :
                                      (PARITY == "odd")  ? PAR_ODD  : PAR_INVALID;

  // Reject unsupported configurations at elaboration
  if (BAUD_DIV < 2) begin : g_err_baud
    $error("uart_tx_axis: BAUD_DIV must be at least 2");
  end
  if (PAR_MODE == PAR_INVALID) begin : g_err_parity
    $error("uart_tx_axis: PARITY must be none, even or odd");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
    $error("uart_tx_axis: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_tx_axis: DATA_BITS must be 5..9");
  end

  logic [STATE_W-1:0]   state, state_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 par_bit, par_bit_d;
  logic                 tx_d, busy_d, tready_d;
  logic                 restart, bit_done_c;

  assign restart = (state == ST_IDLE);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart),
    .bit_done_c (bit_done_c)
  );

  // Next-state and output decode. tx/busy follow the current state, so the
  // line lags the state register by one clock (start bit begins the clock
  // after the handshake edge).
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    par_bit_d  = par_bit;
    tx_d       = 1'b1;
    busy_d     = 1'b1;

    case (state)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (s_axis_tvalid && s_axis_tready) begin
          state_d    = ST_START;
          shift_d    = s_axis_tdata;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_bit_d  = (PAR_MODE == PAR_ODD) ? ~^s_axis_tdata : ^s_axis_tdata;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_done_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_d = shift[0];
        if (bit_done_c) begin
          shift_d = shift >> 1;
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_bit;
        if (bit_done_c) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Ready mirrors the idle state; a registered copy keeps it low in reset
    tready_d = (state_d == ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      par_bit       <= 1'b0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_d;
      shift         <= shift_d;
      bit_cnt       <= bit_cnt_d;
      stop_cnt      <= stop_cnt_d;
      par_bit       <= par_bit_d;
      tx            <= tx_d;
      busy          <= busy_d;
      s_axis_tready <= tready_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Bench for uart_tx_axis: three configurations (default 434-clock bits with even
// parity, 9-bit odd parity with two stop bits, 8-bit no parity) driven with
// directed and random words; the expected line is built from the frame rules.
module tb_uart_tx_axis;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tdata0, tdata2;
  logic [8:0] tdata1;
  logic [2:0] tvalid;
  logic [2:0] tready, tx, busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          exp_bits[$];

  always #5 clk = ~clk;

  uart_tx_axis u_dut0 (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (tdata0), .s_axis_tvalid (tvalid[0]), .s_axis_tready (tready[0]),
    .tx (tx[0]), .busy (busy[0])
  );

  uart_tx_axis #(
    .CLK_FREQ (100), .BAUD (20), .DATA_BITS (9), .PARITY ("odd"), .STOP_BITS (2)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (tdata1), .s_axis_tvalid (tvalid[1]), .s_axis_tready (tready[1]),
    .tx (tx[1]), .busy (busy[1])
  );

  uart_tx_axis #(
    .CLK_FREQ (100), .BAUD (25), .DATA_BITS (8), .PARITY ("none"), .STOP_BITS (1)
  ) u_dut2 (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (tdata2), .s_axis_tvalid (tvalid[2]), .s_axis_tready (tready[2]),
    .tx (tx[2]), .busy (busy[2])
  );

  // Per-instance configuration: clocks per bit, payload bits, parity (0 none, 1 even, 2 odd), stops
  function automatic int unsigned cfg_bd(input int sel);
    case (sel)
      0:       return 50_000_000 / 115200;
      1:       return 100 / 20;
      default: return 100 / 25;
    endcase
  endfunction

  function automatic int unsigned cfg_nbits(input int sel);
    return (sel == 1) ? 9 : 8;
  endfunction

  function automatic int unsigned cfg_par(input int sel);
    case (sel)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned cfg_stop(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line bits for one frame, one entry per bit period
  task automatic build_frame(input int sel, input logic [8:0] word);
    int unsigned ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < int'(cfg_nbits(sel)); i++) begin
      exp_bits.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (cfg_par(sel) == 1) exp_bits.push_back(bit'(ones % 2));
    else if (cfg_par(sel) == 2) exp_bits.push_back(bit'((ones + 1) % 2));
    for (int i = 0; i < int'(cfg_stop(sel)); i++) exp_bits.push_back(1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [8:0] w, input logic v);
    case (sel)
      0:       tdata0 = w[7:0];
      1:       tdata1 = w;
      default: tdata2 = w[7:0];
    endcase
    tvalid[sel] = v;
  endtask

  task automatic idle_check(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_tx", tx[sel], 1'b1);
      check("idle_busy", busy[sel], 1'b0);
      check("idle_tready", tready[sel], 1'b1);
    end
  endtask

  // Offer a word, wait for the handshake, then follow the whole frame on the line.
  // Returns after sampling the last stop-bit clock.
  task automatic send_frame(input int sel, input logic [8:0] word, input bit hold,
                            input bit immediate, input int pulse_at);
    int unsigned bd, f, n, slot, off, busy_cnt;
    build_frame(sel, word);
    bd = cfg_bd(sel);
    f  = exp_bits.size() * bd;
    if (immediate) check("b2b_tready_last_stop", tready[sel], 1'b1);
    drive(sel, word, 1'b1);
    n = 0;
    while (tready[sel] !== 1'b1 && n < 4 * f) begin
      tick();
      n++;
    end
    if (tready[sel] !== 1'b1) begin
      check("handshake_tready", tready[sel], 1'b1);
      drive(sel, word, 1'b0);
      return;
    end
    tick();
    // Handshake edge has passed; scramble tdata to prove it was latched
    drive(sel, 9'($urandom), hold);
    check("hs_tx", tx[sel], 1'b1);
    check("hs_busy", busy[sel], 1'b0);
    check("hs_tready", tready[sel], 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < int'(f); c++) begin
      tick();
      if (pulse_at >= 0) begin
        if (c == pulse_at) tvalid[sel] = 1'b1;
        else if (c == pulse_at + 1) tvalid[sel] = 1'b0;
      end
      if (busy[sel] === 1'b1) busy_cnt++;
      slot = int'(c) / bd;
      off  = int'(c) % bd;
      if (off == 0 || off == bd / 2 || off == bd - 1) begin
        check($sformatf("tx_slot%0d_off%0d", slot, off), tx[sel], exp_bits[slot]);
        check("frame_busy", busy[sel], 1'b1);
        if (off == 0) check("frame_tready", tready[sel], 1'b0);
      end
    end
    check("busy_cycles", busy_cnt, f);
  endtask

  task automatic random_run(input int sel, input int count);
    logic [8:0] w;
    bit hold, prev_hold;
    prev_hold = 1'b0;
    for (int i = 0; i < count; i++) begin
      w    = 9'($urandom_range(0, (1 << cfg_nbits(sel)) - 1));
      hold = (i == count - 1) ? 1'b0 : bit'($urandom_range(0, 1));
      send_frame(sel, w, hold, prev_hold, -1);
      if (!hold) idle_check(sel, $urandom_range(0, 3));
      prev_hold = hold;
    end
    idle_check(sel, 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    tvalid = '0;
    tdata0 = '0;
    tdata1 = '0;
    tdata2 = '0;
    repeat (3) tick();
    check("rst_tx", tx, 3'b111);
    check("rst_busy", busy, 3'b000);
    check("rst_tready", tready, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_tready", tready, 3'b111);
    check("rel_tx", tx, 3'b111);
    check("rel_busy", busy, 3'b000);

    // Reset in the middle of a start bit aborts the frame at once
    drive(0, 9'h03C, 1'b1);
    tick();
    drive(0, 9'h000, 1'b0);
    repeat (200) tick();
    check("pre_rst_tx", tx[0], 1'b0);
    check("pre_rst_busy", busy[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx[0], 1'b1);
    check("mid_rst_busy", busy[0], 1'b0);
    check("mid_rst_tready", tready[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel2_tready", tready[0], 1'b1);
    idle_check(0, 4);

    // Even parity frame, then back-to-back pair, then tvalid pulsed mid-frame
    send_frame(0, 9'h055, 1'b0, 1'b0, -1);
    idle_check(0, 3);
    send_frame(0, 9'h001, 1'b1, 1'b0, -1);
    send_frame(0, 9'h080, 1'b0, 1'b1, -1);
    idle_check(0, 3);
    send_frame(0, 9'h0C3, 1'b0, 1'b0, 1000);
    idle_check(0, 2 * int'(cfg_bd(0)));

    // Odd parity, nine data bits, two stops; and no-parity frame
    send_frame(1, 9'h0A5, 1'b0, 1'b0, -1);
    idle_check(1, 3);
    send_frame(2, 9'h0FF, 1'b0, 1'b0, -1);
    idle_check(2, 3);

    random_run(1, 256);
    random_run(2, 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
